alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 44 ++++
 rtl/alu_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// Requester, response and shared-ALU signals of alu_arbiter.
// The arbiter uses the slave modport; requesters plus the external ALU use master.
interface alu_arbiter_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             req0_valid;
  logic             req0_ready;
  logic [2:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [2:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             rsp0_valid;
  logic             rsp1_valid;
  logic [WIDTH-1:0] rsp_y;
  logic             rsp_zero;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_select;
  logic [WIDTH-1:0] alu_y;
  logic             alu_zero;
  logic             busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  alu_y, alu_zero,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_y, rsp_zero,
    output alu_a, alu_b, alu_select, busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output alu_y, alu_zero,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_y, rsp_zero,
    input  alu_a, alu_b, alu_select, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU, one operation in flight.
// Define ALU_ARBITER_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module alu_arbiter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);
  localparam int unsigned CNT_W  = 4;
  localparam logic [2:0]  OP_MUL = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_grant;
  logic [2:0]       r_alu_select;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [WIDTH-1:0] r_rsp_y;
  logic             r_rsp_zero;
  logic             r_rsp0_valid;
  logic             r_rsp1_valid;
  logic             r_busy;

  logic             w_pick;
  logic             w_accept;
  logic             w_capture;
  logic [2:0]       w_op;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;

`ifdef ALU_ARBITER_RR_EN
  logic r_last_grant;

  // On a tie, grant the port that did not win last time.
  always_comb begin
    if (bus.req0_valid && bus.req1_valid) begin
      w_pick = ~r_last_grant;
    end else begin
      w_pick = bus.req1_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_last_grant <= w_pick;
    end
  end
`else
  always_comb begin
    w_pick = ~bus.req0_valid;
  end
`endif

  // Payload of the port being granted.
  always_comb begin
    w_op = w_pick ? bus.req1_op : bus.req0_op;
    w_a  = w_pick ? bus.req1_a  : bus.req0_a;
    w_b  = w_pick ? bus.req1_b  : bus.req0_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state; ready is gated with rst_n so nothing is granted while in reset.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (rst_n && (bus.req0_valid || bus.req1_valid)) begin
          w_accept    = 1'b1;
          w_state_nxt = EXEC;
          w_cnt_nxt   = (w_op == OP_MUL) ? CNT_W'(MUL_LAT - 1) : '0;
        end
      end
      EXEC: begin
        if (r_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = DONE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // ALU drive holds the accepted operation only while in EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant      <= 1'b0;
      r_alu_select <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_rsp_y      <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_rsp0_valid <= w_capture & ~r_grant;
      r_rsp1_valid <= w_capture & r_grant;
      r_busy       <= (w_state_nxt != IDLE);
      if (w_accept) begin
        r_grant      <= w_pick;
        r_alu_select <= w_op;
        r_alu_a      <= w_a;
        r_alu_b      <= w_b;
      end else if (w_capture) begin
        r_alu_select <= '0;
        r_alu_a      <= '0;
        r_alu_b      <= '0;
        r_rsp_y      <= bus.alu_y;
        r_rsp_zero   <= bus.alu_zero;
      end
    end
  end

  assign bus.req0_ready = w_accept & ~w_pick;
  assign bus.req1_ready = w_accept & w_pick;
  assign bus.rsp0_valid = r_rsp0_valid;
  assign bus.rsp1_valid = r_rsp1_valid;
  assign bus.rsp_y      = r_rsp_y;
  assign bus.rsp_zero   = r_rsp_zero;
  assign bus.alu_select = r_alu_select;
  assign bus.alu_a      = r_alu_a;
  assign bus.alu_b      = r_alu_b;
  assign bus.busy       = r_busy;

endmodule
